// File: rtl/fifo_pkg.sv
// Shared defaults for the threshold FIFO: word/address widths and the
// occupancy-count width derivation used by sync_fifo_thr.
package fifo_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_ADDR_WIDTH = 8;

   // count must represent 0..DEPTH inclusive, hence one bit wider than the pointers
   function automatic int count_width(input int addr_width);
      return addr_width + 1;
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage array: one synchronous write port, one
// asynchronous read port, contents are never reset.
module fifo_ram #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_thr.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds,
// occupancy count and sticky error flags. Define FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_thr
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
   parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 4,
   parameter int AEMPTY_THRESH = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [DATA_WIDTH-1:0]                din,
   input  logic                                 wr_en,
   input  logic                                 rd_en,
   input  logic                                 clr_err,
   output logic [DATA_WIDTH-1:0]                dout,
   output logic                                 valid,
   output logic                                 empty,
   output logic                                 full,
   output logic                                 almost_empty,
   output logic                                 almost_full,
   output logic [count_width(ADDR_WIDTH)-1:0]   count,
   output logic                                 overflow,
   output logic                                 underflow
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int CW    = count_width(ADDR_WIDTH);

   logic [ADDR_WIDTH-1:0] write_ptr;
   logic [ADDR_WIDTH-1:0] read_ptr;
   logic [DATA_WIDTH-1:0] ram_rdata;
   logic                  wr_acc;
   logic                  rd_acc;

   // A full FIFO still accepts a write when a read frees a slot on the same edge
   assign rd_acc = rd_en && !empty;
   assign wr_acc = wr_en && (!full || rd_acc);

   assign empty        = (count == '0);
   assign full         = (count == CW'(DEPTH));
   assign almost_empty = (int'(count) <= AEMPTY_THRESH);
   assign almost_full  = (int'(count) >= AFULL_THRESH);

   fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (write_ptr),
      .wdata (din),
      .raddr (read_ptr),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         write_ptr <= '0;
         read_ptr  <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_acc) begin
            write_ptr <= write_ptr + ADDR_WIDTH'(1);
         end
         if (rd_acc) begin
            read_ptr <= read_ptr + ADDR_WIDTH'(1);
         end
         count <= count + CW'(wr_acc) - CW'(rd_acc);
         // clr_err wins over a rejection on the same edge
         if (clr_err) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
         end else begin
            if (wr_en && !wr_acc) begin
               overflow <= 1'b1;
            end
            if (rd_en && !rd_acc) begin
               underflow <= 1'b1;
            end
         end
      end
   end

`ifdef FIFO_FWFT_EN
   assign dout  = ram_rdata;
   assign valid = !empty;
`else
   logic [DATA_WIDTH-1:0] dout_q;
   logic                  valid_q;

   // Popped word is registered; dout keeps its last value once valid drops
   always_ff @(posedge clk) begin
      if (rst) begin
         dout_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= rd_acc;
         if (rd_acc) begin
            dout_q <= ram_rdata;
         end
      end
   end

   assign dout  = dout_q;
   assign valid = valid_q;
`endif

endmodule
